// File: rtl/fetch_stage_pkg.sv
// Core-wide shared definitions: XLEN, canonical NOP, default reset PC and
// the RV32I major opcodes used by decode, plus small PC helper functions.
package fetch_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_2000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Source selection for the next fetch address.
  typedef enum logic [1:0] {
    PC_SEL_RESET    = 2'd0,
    PC_SEL_REDIRECT = 2'd1,
    PC_SEL_HOLD     = 2'd2,
    PC_SEL_SEQ      = 2'd3
  } pc_sel_e;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: PC register, next-PC selection (reset > redirect > stall
// > sequential), forced word alignment and the sticky misaligned-target flag.
module pc_counter
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              IMEM_AW  = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic [XLEN-1:0]     pc,
  output logic [IMEM_AW-1:0]  imem_addr,
  output logic                load,
  output logic                misalign_err
);

  pc_sel_e         pc_sel_s;
  logic [XLEN-1:0] next_pc_s;
  logic            load_s;
  logic [XLEN-1:0] pc_r;
  logic            misalign_r;

  // Next-PC source selection and address mux.
  always_comb begin
    pc_sel_s  = PC_SEL_HOLD;
    next_pc_s = pc_r;
    load_s    = 1'b0;
    if (!rst_n) begin
      pc_sel_s = PC_SEL_RESET;
    end else if (redirect_valid) begin
      pc_sel_s = PC_SEL_REDIRECT;
    end else if (stall) begin
      pc_sel_s = PC_SEL_HOLD;
    end else begin
      pc_sel_s = PC_SEL_SEQ;
    end
    case (pc_sel_s)
      PC_SEL_RESET:    next_pc_s = RESET_PC;
      PC_SEL_REDIRECT: next_pc_s = align_word(redirect_pc);
      PC_SEL_HOLD:     next_pc_s = pc_r;
      PC_SEL_SEQ:      next_pc_s = pc_r + PC_STEP;
      default:         next_pc_s = pc_r;
    endcase
    // Reset keeps imem reading so the RESET_PC word is ready on release.
    load_s = (pc_sel_s != PC_SEL_HOLD);
  end

  // PC register and sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r       <= RESET_PC - PC_STEP;
      misalign_r <= 1'b0;
    end else begin
      if (load_s) begin
        pc_r <= next_pc_s;
      end
      if (redirect_valid && is_misaligned(redirect_pc)) begin
        misalign_r <= 1'b1;
      end
    end
  end

  assign pc           = pc_r;
  assign imem_addr    = next_pc_s[IMEM_AW+1:2];
  assign load         = load_s;
  assign misalign_err = misalign_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the synchronous imem, tracks IF/ID validity,
// substitutes a NOP for invalid slots and counts instructions handed to decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              IMEM_AW   = 14,
  parameter int              CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc,
  input  logic [XLEN-1:0]       imem_dout,
  output logic [IMEM_AW-1:0]    imem_addr,
  output logic                  imem_en,
  output logic [XLEN-1:0]       inst_id,
  output logic [XLEN-1:0]       pc_id,
  output logic                  valid_id,
  output logic                  misalign_err,
  output logic [CNT_WIDTH-1:0]  fetch_count
);

  logic                 load_s;
  logic                 valid_r;
  logic                 deliver_s;
  logic [CNT_WIDTH-1:0] count_r;

  pc_counter #(
    .RESET_PC (RESET_PC),
    .IMEM_AW  (IMEM_AW)
  ) u_pc_counter (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc_id),
    .imem_addr      (imem_addr),
    .load           (load_s),
    .misalign_err   (misalign_err)
  );

  // An instruction leaves ID when it is valid, not held and not squashed.
  assign deliver_s = valid_r & ~stall & ~redirect_valid;

  // IF/ID valid flag: set by any fetch, held while imem is idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
    end else if (load_s) begin
      valid_r <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Delivered-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= {CNT_WIDTH{1'b0}};
    end else if (deliver_s) begin
      count_r <= count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  // Decode sees imem data only for valid slots, otherwise a canonical NOP.
  always_comb begin
    inst_id = NOP_INST;
    if (valid_r) begin
      inst_id = imem_dout;
    end else begin
      inst_id = NOP_INST;
    end
  end

  assign imem_en     = load_s;
  assign valid_id    = valid_r;
  assign fetch_count = count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a synchronous imem model;
// a CNT_WIDTH=4 instance shares the stimulus to exercise counter wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic [31:0] imem_dout, imem_dout4;
  logic [13:0] imem_addr, imem_addr4;
  logic        imem_en, imem_en4;
  logic [31:0] inst_id, inst_id4, pc_id, pc_id4;
  logic        valid_id, valid_id4, misalign_err, misalign_err4;
  logic [31:0] fetch_count;
  logic [3:0]  fetch_count4;

  logic [31:0] mem [0:16383];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_dout(imem_dout), .imem_addr(imem_addr),
    .imem_en(imem_en), .inst_id(inst_id), .pc_id(pc_id), .valid_id(valid_id),
    .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  fetch_stage #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_dout(imem_dout4), .imem_addr(imem_addr4),
    .imem_en(imem_en4), .inst_id(inst_id4), .pc_id(pc_id4), .valid_id(valid_id4),
    .misalign_err(misalign_err4), .fetch_count(fetch_count4)
  );

  always @(posedge clk) begin
    if (imem_en)  imem_dout  <= mem[imem_addr];
    if (imem_en4) imem_dout4 <= mem[imem_addr4];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[14'h0800] = 32'h0050_0093;

    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    check_eq("rst_valid", {31'd0, valid_id}, 32'd0);
    check_eq("rst_inst", inst_id, 32'h0000_0013);
    check_eq("rst_en", {31'd0, imem_en}, 32'd1);
    check_eq("rst_addr", {18'd0, imem_addr}, 32'h0000_0800);
    check_eq("rst_pc", pc_id, 32'h0000_1FFC);
    check_eq("rst_cnt", fetch_count, 32'd0);
    check_eq("rst_mis", {31'd0, misalign_err}, 32'd0);

    rst_n = 1'b1;
    tick();
    check_eq("c1_pc", pc_id, 32'h0000_2000);
    check_eq("c1_inst", inst_id, 32'h0050_0093);
    check_eq("c1_valid", {31'd0, valid_id}, 32'd1);
    check_eq("c1_cnt", fetch_count, 32'd0);
    tick();
    check_eq("c2_pc", pc_id, 32'h0000_2004);
    check_eq("c2_inst", inst_id, 32'hC0DE_0801);
    check_eq("c2_cnt", fetch_count, 32'd1);
    tick();
    check_eq("c3_pc", pc_id, 32'h0000_2008);

    stall = 1'b1;
    #1;
    check_eq("stall_en", {31'd0, imem_en}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_pc", pc_id, 32'h0000_2008);
      check_eq("stall_inst", inst_id, 32'hC0DE_0802);
      check_eq("stall_cnt", fetch_count, 32'd2);
      check_eq("stall_en2", {31'd0, imem_en}, 32'd0);
    end
    stall = 1'b0;
    tick();
    check_eq("unstall_pc", pc_id, 32'h0000_200C);
    check_eq("unstall_cnt", fetch_count, 32'd3);

    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_2100;
    #1;
    check_eq("redir_en", {31'd0, imem_en}, 32'd1);
    tick();
    check_eq("redir_pc", pc_id, 32'h0000_2100);
    check_eq("redir_inst", inst_id, 32'hC0DE_0840);
    check_eq("redir_valid", {31'd0, valid_id}, 32'd1);
    check_eq("redir_cnt", fetch_count, 32'd3);
    check_eq("redir_mis", {31'd0, misalign_err}, 32'd0);

    stall = 1'b0; redirect_pc = 32'h0000_2102;
    tick();
    check_eq("mis_pc", pc_id, 32'h0000_2100);
    check_eq("mis_flag", {31'd0, misalign_err}, 32'd1);
    check_eq("mis_cnt", fetch_count, 32'd3);
    redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("mis_sticky", {31'd0, misalign_err}, 32'd1);
    end
    check_eq("seq_pc", pc_id, 32'h0000_2128);
    check_eq("seq_cnt", fetch_count, 32'd13);

    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    check_eq("top_pc", pc_id, 32'hFFFF_FFFC);
    check_eq("top_inst", inst_id, 32'hC0DE_3FFF);
    redirect_valid = 1'b0;
    tick();
    check_eq("wrap_pc", pc_id, 32'h0000_0000);
    check_eq("wrap_inst", inst_id, 32'hC0DE_0000);
    check_eq("wrap_cnt", fetch_count, 32'd14);

    rst_n = 1'b0; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
    tick(); tick();
    check_eq("rst2_mis", {31'd0, misalign_err}, 32'd0);
    check_eq("rst2_valid", {31'd0, valid_id}, 32'd0);
    check_eq("rst2_cnt", fetch_count, 32'd0);
    check_eq("rst2_addr", {18'd0, imem_addr}, 32'h0000_0800);
    check_eq("rst2_en", {31'd0, imem_en}, 32'd1);
    rst_n = 1'b1; redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("hold_valid", {31'd0, valid_id}, 32'd0);
      check_eq("hold_inst", inst_id, 32'h0000_0013);
      check_eq("hold_pc", pc_id, 32'h0000_1FFC);
    end
    stall = 1'b0;
    tick();
    check_eq("go_pc", pc_id, 32'h0000_2000);
    check_eq("go_valid", {31'd0, valid_id}, 32'd1);
    check_eq("go_inst", inst_id, 32'h0050_0093);
    check_eq("go_cnt4", {28'd0, fetch_count4}, 32'd0);

    for (int i = 0; i < 15; i++) tick();
    check_eq("cnt4_15", {28'd0, fetch_count4}, 32'd15);
    check_eq("cnt_15", fetch_count, 32'd15);
    tick();
    check_eq("cnt4_wrap", {28'd0, fetch_count4}, 32'd0);
    check_eq("cnt_16", fetch_count, 32'd16);
    check_eq("pc4_seq", pc_id4, 32'h0000_2040);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
